// File: rtl/i2c_init_sequencer_if.sv
// Command handshake between the init sequencer (master) and the I2C transmitter (slave).
// The sequencer presents one register write at a time under data_valid_o/ready.
interface i2c_init_sequencer_if;
   logic [15:0] reg_addr_o;
   logic [7:0]  reg_data_o;
   logic        rw_bit_o;
   logic [1:0]  i2c_tx_phases_o;
   logic        data_valid_o;
   logic        i2c_transmitter_ready;

   modport master (
      output reg_addr_o,
      output reg_data_o,
      output rw_bit_o,
      output i2c_tx_phases_o,
      output data_valid_o,
      input  i2c_transmitter_ready
   );

   modport slave (
      input  reg_addr_o,
      input  reg_data_o,
      input  rw_bit_o,
      input  i2c_tx_phases_o,
      input  data_valid_o,
      output i2c_transmitter_ready
   );
endinterface

// File: rtl/i2c_init_sequencer.sv
// Table-driven bring-up sequencer: walks a synchronous ROM of WRITE/DELAY/END entries and
// hands each register write to the I2C transmitter, with settle delays and a per-entry timeout.
module i2c_init_sequencer #(
   parameter int unsigned ROM_AW         = 8,
   parameter int unsigned DELAY_UNIT     = 1000,
   parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 trigger_i,
   output logic [ROM_AW-1:0]    rom_addr_o,
   input  logic [25:0]          rom_data_i,
   i2c_init_sequencer_if.master tx,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 error_o
);

   localparam int unsigned DLY_W = 24 + $clog2(DELAY_UNIT + 1);
   localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [1:0]        OP_WRITE = 2'd0;
   localparam logic [1:0]        OP_DELAY = 2'd1;
   localparam logic [1:0]        OP_END   = 2'd2;
   localparam logic [ROM_AW-1:0] LAST_IDX = '1;
   localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_LOAD,
      S_DECODE,
      S_SEND,
      S_WAIT_TX,
      S_DELAY,
      S_DONE,
      S_ERROR
   } state_t;

   state_t             r_state;
   logic [ROM_AW-1:0]  r_index;
   logic [DLY_W-1:0]   r_dly_cnt;
   logic [TO_W-1:0]    r_to_cnt;
   logic               r_tx_first;

   logic               w_last_idx;
   logic               w_timeout;
   logic               w_accept;
   logic [DLY_W-1:0]   w_dly_load;

   assign w_last_idx = (r_index == LAST_IDX);
   assign w_timeout  = (r_to_cnt >= TO_LAST);
   assign w_accept   = tx.data_valid_o && tx.i2c_transmitter_ready;
   assign w_dly_load = DLY_W'(rom_data_i[23:0]) * DLY_W'(DELAY_UNIT);

   // Only register writes are ever issued, always with both address and data phases.
   assign tx.rw_bit_o        = 1'b0;
   assign tx.i2c_tx_phases_o = 2'b11;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state         <= S_IDLE;
         r_index         <= '0;
         r_dly_cnt       <= '0;
         r_to_cnt        <= '0;
         r_tx_first      <= 1'b0;
         rom_addr_o      <= '0;
         tx.reg_addr_o   <= '0;
         tx.reg_data_o   <= '0;
         tx.data_valid_o <= 1'b0;
         busy_o          <= 1'b0;
         done_o          <= 1'b0;
         error_o         <= 1'b0;
      end else begin
         case (r_state)
            // Idle and both terminal states restart the table from entry 0.
            S_IDLE, S_DONE, S_ERROR: begin
               if (trigger_i) begin
                  r_index <= '0;
                  done_o  <= 1'b0;
                  error_o <= 1'b0;
                  busy_o  <= 1'b1;
                  r_state <= S_FETCH;
               end
            end

            S_FETCH: begin
               rom_addr_o <= r_index;
               r_state    <= S_LOAD;
            end

            S_LOAD: begin
               r_state <= S_DECODE;
            end

            S_DECODE: begin
               case (rom_data_i[25:24])
                  OP_WRITE: begin
                     tx.reg_addr_o <= rom_data_i[23:8];
                     tx.reg_data_o <= rom_data_i[7:0];
                     r_to_cnt      <= '0;
                     r_state       <= S_SEND;
                  end
                  OP_DELAY: begin
                     r_dly_cnt <= w_dly_load;
                     r_state   <= S_DELAY;
                  end
                  OP_END: begin
                     done_o  <= 1'b1;
                     busy_o  <= 1'b0;
                     r_state <= S_DONE;
                  end
                  default: begin
                     error_o <= 1'b1;
                     busy_o  <= 1'b0;
                     r_state <= S_ERROR;
                  end
               endcase
            end

            // Hold valid with stable address/data until the transmitter takes it.
            S_SEND: begin
               if (w_accept) begin
                  tx.data_valid_o <= 1'b0;
                  r_tx_first      <= 1'b1;
                  r_to_cnt        <= r_to_cnt + TO_W'(1);
                  r_state         <= S_WAIT_TX;
               end else if (w_timeout) begin
                  tx.data_valid_o <= 1'b0;
                  error_o         <= 1'b1;
                  busy_o          <= 1'b0;
                  r_state         <= S_ERROR;
               end else begin
                  tx.data_valid_o <= 1'b1;
                  r_to_cnt        <= r_to_cnt + TO_W'(1);
               end
            end

            // Ready is still high on the first cycle after acceptance, so skip it.
            S_WAIT_TX: begin
               if (!r_tx_first && tx.i2c_transmitter_ready) begin
                  if (w_last_idx) begin
                     error_o <= 1'b1;
                     busy_o  <= 1'b0;
                     r_state <= S_ERROR;
                  end else begin
                     r_index <= r_index + ROM_AW'(1);
                     r_state <= S_FETCH;
                  end
               end else if (w_timeout) begin
                  error_o <= 1'b1;
                  busy_o  <= 1'b0;
                  r_state <= S_ERROR;
               end else begin
                  r_tx_first <= 1'b0;
                  r_to_cnt   <= r_to_cnt + TO_W'(1);
               end
            end

            // Stays ticks*DELAY_UNIT cycles, with a zero-tick entry still taking one.
            S_DELAY: begin
               if (r_dly_cnt < DLY_W'(2)) begin
                  if (w_last_idx) begin
                     error_o <= 1'b1;
                     busy_o  <= 1'b0;
                     r_state <= S_ERROR;
                  end else begin
                     r_index <= r_index + ROM_AW'(1);
                     r_state <= S_FETCH;
                  end
               end else begin
                  r_dly_cnt <= r_dly_cnt - DLY_W'(1);
               end
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Directed bench for i2c_init_sequencer: two instances (small table / short timeout, and a
// long-timeout one for the stalled-ready case) each with a ROM and a transmitter model.
module tb_i2c_init_sequencer;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic reset_n;
   logic trig_a, trig_b;
   logic busy_a, done_a, err_a;
   logic busy_b, done_b, err_b;

   logic [1:0]  rom_addr_a;
   logic [25:0] rom_q_a;
   logic [25:0] rom_a [4];
   logic [3:0]  rom_addr_b;
   logic [25:0] rom_q_b;
   logic [25:0] rom_b [16];

   i2c_init_sequencer_if txa ();
   i2c_init_sequencer_if txb ();

   i2c_init_sequencer #(.ROM_AW(2), .DELAY_UNIT(10), .TIMEOUT_CYCLES(64)) dut_a (
      .clock      (clock),
      .reset_n    (reset_n),
      .trigger_i  (trig_a),
      .rom_addr_o (rom_addr_a),
      .rom_data_i (rom_q_a),
      .tx         (txa),
      .busy_o     (busy_a),
      .done_o     (done_a),
      .error_o    (err_a)
   );

   i2c_init_sequencer #(.ROM_AW(4), .DELAY_UNIT(10), .TIMEOUT_CYCLES(1024)) dut_b (
      .clock      (clock),
      .reset_n    (reset_n),
      .trigger_i  (trig_b),
      .rom_addr_o (rom_addr_b),
      .rom_data_i (rom_q_b),
      .tx         (txb),
      .busy_o     (busy_b),
      .done_o     (done_b),
      .error_o    (err_b)
   );

   // Synchronous ROMs: data valid one cycle after the address.
   always @(posedge clock) rom_q_a <= rom_a[rom_addr_a];
   always @(posedge clock) rom_q_b <= rom_b[rom_addr_b];

   // Transmitter models: drop ready for hold_len cycles after each acceptance.
   bit          stuck_a, stuck_b;
   int          hold_len_a, hold_len_b;
   int          hold_a, hold_b;
   int          vcnt_a;
   logic [23:0] acc_a [$];
   logic [23:0] acc_b [$];

   assign txa.i2c_transmitter_ready = !stuck_a && (hold_a == 0);
   assign txb.i2c_transmitter_ready = !stuck_b && (hold_b == 0);

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) hold_a <= 0;
      else if (txa.data_valid_o && txa.i2c_transmitter_ready) begin
         acc_a.push_back({txa.reg_addr_o, txa.reg_data_o});
         hold_a <= hold_len_a;
      end else if (hold_a != 0) hold_a <= hold_a - 1;
   end

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) hold_b <= 0;
      else if (txb.data_valid_o && txb.i2c_transmitter_ready) begin
         acc_b.push_back({txb.reg_addr_o, txb.reg_data_o});
         hold_b <= hold_len_b;
      end else if (hold_b != 0) hold_b <= hold_b - 1;
   end

   always @(posedge clock) if (txa.data_valid_o) vcnt_a <= vcnt_a + 1;

   int n_total = 0;
   int n_bad   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [25:0] op_wr(input logic [15:0] a, input logic [7:0] d);
      return {2'b00, a, d};
   endfunction

   function automatic logic [25:0] op_dly(input logic [23:0] t);
      return {2'b01, t};
   endfunction

   localparam logic [25:0] OP_END_E = {2'b10, 24'd0};
   localparam logic [25:0] OP_RSV_E = {2'b11, 24'h123456};

   // 0: A valid, 1: A done|error, 2: B valid, 3: B done|error
   function automatic logic cond(input int which);
      case (which)
         0:       return txa.data_valid_o;
         1:       return done_a | err_a;
         2:       return txb.data_valid_o;
         default: return done_b | err_b;
      endcase
   endfunction

   // n counts negedges after the one that follows the sampling edge of the trigger.
   task automatic wait_for(input int which, input int budget, input string tag, output int n);
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!cond(which) && n < budget);
      check_eq({tag, "_bound"}, 32'(cond(which)), 32'd1);
   endtask

   task automatic pulse(input bit sel_b);
      @(negedge clock);
      if (sel_b) trig_b = 1'b1;
      else       trig_a = 1'b1;
      @(negedge clock);
      trig_a = 1'b0;
      trig_b = 1'b0;
   endtask

   int n, base, vbase, stable;

   initial begin
      reset_n = 1'b0; trig_a = 1'b0; trig_b = 1'b0;
      stuck_a = 1'b0; stuck_b = 1'b0; hold_len_a = 50; hold_len_b = 3;
      for (int i = 0; i < 4; i++)  rom_a[i] = OP_END_E;
      for (int i = 0; i < 16; i++) rom_b[i] = OP_END_E;

      // Reset values
      repeat (3) @(negedge clock);
      check_eq("rst_rom_addr", 32'(rom_addr_a), 32'd0);
      check_eq("rst_reg_addr", 32'(txa.reg_addr_o), 32'd0);
      check_eq("rst_reg_data", 32'(txa.reg_data_o), 32'd0);
      check_eq("rst_vbde", 32'({txa.data_valid_o, busy_a, done_a, err_a}), 32'd0);
      check_eq("rst_rw", 32'(txa.rw_bit_o), 32'd0);
      check_eq("rst_phases", 32'(txa.i2c_tx_phases_o), 32'd3);
      reset_n = 1'b1;
      @(negedge clock);

      // Two writes then END, 50-cycle transmitter busy time
      rom_a[0] = op_wr(16'h3008, 8'h82);
      rom_a[1] = op_wr(16'h3103, 8'h03);
      rom_a[2] = OP_END_E;
      base = acc_a.size();
      pulse(1'b0);
      check_eq("t1_busy_start", 32'(busy_a), 32'd1);
      wait_for(0, 20, "t1_dv", n);
      check_eq("t1_dv_latency", 32'(n), 32'd4);
      check_eq("t1_first_addr", 32'(txa.reg_addr_o), 32'h3008);
      repeat (10) @(negedge clock);
      pulse(1'b0);
      wait_for(1, 1000, "t1_end", n);
      check_eq("t1_bde", 32'({busy_a, done_a, err_a}), 32'b010);
      check_eq("t1_count", 32'(acc_a.size() - base), 32'd2);
      check_eq("t1_cmd0", 32'(acc_a[base]), 32'h300882);
      check_eq("t1_cmd1", 32'(acc_a[base + 1]), 32'h310303);
      check_eq("t1_rom_addr", 32'(rom_addr_a), 32'd2);

      // Delay: 30 clocks in DELAY plus 3 fetch/load/decode cycles per entry
      rom_a[0] = op_dly(24'd3);
      rom_a[1] = OP_END_E;
      pulse(1'b0);
      wait_for(1, 200, "t2_dly3", n);
      check_eq("t2_dly3_cycles", 32'(n), 32'd36);
      check_eq("t2_dly3_done", 32'(done_a), 32'd1);
      rom_a[0] = op_dly(24'd0);
      pulse(1'b0);
      wait_for(1, 200, "t2_dly0", n);
      check_eq("t2_dly0_cycles", 32'(n), 32'd7);
      rom_a[0] = OP_END_E;
      pulse(1'b0);
      wait_for(1, 200, "t2_end", n);
      check_eq("t2_end_cycles", 32'(n), 32'd3);

      // Timeout with ready stuck low: 64 cycles in SEND
      stuck_a  = 1'b1;
      rom_a[0] = op_wr(16'h1234, 8'h56);
      rom_a[1] = OP_END_E;
      base = acc_a.size();
      pulse(1'b0);
      wait_for(1, 200, "t3_to", n);
      check_eq("t3_to_cycles", 32'(n), 32'd67);
      check_eq("t3_bde", 32'({busy_a, done_a, err_a}), 32'b001);
      check_eq("t3_valid", 32'(txa.data_valid_o), 32'd0);
      check_eq("t3_count", 32'(acc_a.size() - base), 32'd0);
      stuck_a = 1'b0;
      pulse(1'b0);
      check_eq("t3_retrig_be", 32'({busy_a, err_a}), 32'b10);
      wait_for(1, 500, "t3_rerun", n);
      check_eq("t3_rerun_bde", 32'({busy_a, done_a, err_a}), 32'b010);
      check_eq("t3_rerun_cmd", 32'(acc_a[base]), 32'h123456);

      // Overrun: four writes, no END, in a 4-entry table
      hold_len_a = 2;
      for (int i = 0; i < 4; i++) rom_a[i] = op_wr(16'hA000 + 16'(i), 8'(i));
      base = acc_a.size();
      pulse(1'b0);
      wait_for(1, 500, "t4_ovr", n);
      check_eq("t4_bde", 32'({busy_a, done_a, err_a}), 32'b001);
      check_eq("t4_count", 32'(acc_a.size() - base), 32'd4);
      check_eq("t4_last", 32'(acc_a[base + 3]), 32'hA00303);

      // Reserved opcode at entry 0
      rom_a[0] = OP_RSV_E;
      vbase = vcnt_a;
      pulse(1'b0);
      wait_for(1, 50, "t5_rsv", n);
      check_eq("t5_bde", 32'({busy_a, done_a, err_a}), 32'b001);
      check_eq("t5_no_valid", 32'(vcnt_a - vbase), 32'd0);

      // Asynchronous reset while waiting on the second write
      hold_len_a = 50;
      rom_a[0] = op_wr(16'h1111, 8'h11);
      rom_a[1] = op_wr(16'h2222, 8'h22);
      rom_a[2] = OP_END_E;
      base = acc_a.size();
      pulse(1'b0);
      n = 0;
      while ((acc_a.size() - base) < 2 && n < 500) begin
         @(negedge clock);
         n++;
      end
      check_eq("t6_two_acc", 32'(acc_a.size() - base), 32'd2);
      repeat (5) @(negedge clock);
      check_eq("t6_pre_rom_addr", 32'(rom_addr_a), 32'd1);
      reset_n = 1'b0;
      #1;
      check_eq("t6_rst_rom_addr", 32'(rom_addr_a), 32'd0);
      check_eq("t6_rst_reg", 32'({txa.reg_addr_o, txa.reg_data_o}), 32'd0);
      check_eq("t6_rst_vbde", 32'({txa.data_valid_o, busy_a, done_a, err_a}), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      repeat (20) @(negedge clock);
      check_eq("t6_no_resume", 32'({txa.data_valid_o, busy_a, done_a}), 32'd0);
      check_eq("t6_count", 32'(acc_a.size() - base), 32'd2);

      // Ready held low 200 cycles during SEND on the long-timeout instance
      stuck_b  = 1'b1;
      rom_b[0] = op_wr(16'hBEEF, 8'h5A);
      rom_b[1] = OP_END_E;
      base = acc_b.size();
      pulse(1'b1);
      wait_for(2, 20, "t7_dv", n);
      check_eq("t7_dv_latency", 32'(n), 32'd4);
      stable = 0;
      for (int i = 0; i < 200; i++) begin
         if (txb.data_valid_o && txb.reg_addr_o == 16'hBEEF && txb.reg_data_o == 8'h5A)
            stable++;
         @(negedge clock);
      end
      check_eq("t7_stable", 32'(stable), 32'd200);
      stuck_b = 1'b0;
      @(negedge clock);
      check_eq("t7_valid_drop", 32'(txb.data_valid_o), 32'd0);
      check_eq("t7_count", 32'(acc_b.size() - base), 32'd1);
      check_eq("t7_cmd", 32'(acc_b[base]), 32'hBEEF5A);
      wait_for(3, 200, "t7_end", n);
      check_eq("t7_bde", 32'({busy_b, done_b, err_b}), 32'b010);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
